sr_drive_ctrl: RTL

Upstream driver for the NAND SR latch. Converts two raw, asynchronous pushbutton inputs into clean, fixed-width, active-low S/R pulses, and connects directly to the latch `S`/`R` inputs. Both pulses are never low at the same time, so the latch never enters its forbidden S=R=0 state. Simultaneous or overlapping requests are arbitrated and flagged.

---
 rtl/sr_drive_pkg.sv | 16 +
 rtl/btn_conditioner.sv | 67 ++++++
 rtl/sr_drive_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/sr_drive_pkg.sv
// Shared types and defaults for the NAND SR latch driver.
// Optional debounce counters are enabled by SR_DRIVE_DEBOUNCE_EN.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SET_PULSE   = 2'd1,
        RESET_PULSE = 2'd2,
        GAP         = 2'd3
    } sr_state_t;

    localparam logic        OUT_IDLE            = 1'b1;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;

endpackage

// File: rtl/btn_conditioner.sv
// Synchronizer, debounce and rising-edge request for one pushbutton.
// Debounce counter exists only when SR_DRIVE_DEBOUNCE_EN is defined.
module btn_conditioner
    import sr_drive_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic req
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef SR_DRIVE_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The flip happens on the sample that would bring the count to N.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign req = level & ~level_d;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Arbitrating pulse driver for the NAND SR latch S/R inputs.
// Build option SR_DRIVE_DEBOUNCE_EN adds input debounce counters.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CYCLES - 1);

    sr_state_t     state;
    logic [PW-1:0] pcnt;
    logic          set_req;
    logic          reset_req;

    if (PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("PULSE_CYCLES must be >= 1");
    end

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .clk (clk),
        .rst (rst),
        .btn (btn_set),
        .req (set_req)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
        .clk (clk),
        .rst (rst),
        .btn (btn_reset),
        .req (reset_req)
    );

    // Outputs are written alongside the state so they track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            S        <= OUT_IDLE;
            R        <= OUT_IDLE;
            busy     <= 1'b0;
            conflict <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            conflict <= 1'b0;
            dropped  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (set_req && reset_req) begin
                        conflict <= 1'b1;
                    end else if (set_req) begin
                        state <= SET_PULSE;
                        pcnt  <= '0;
                        S     <= ~OUT_IDLE;
                        busy  <= 1'b1;
                    end else if (reset_req) begin
                        state <= RESET_PULSE;
                        pcnt  <= '0;
                        R     <= ~OUT_IDLE;
                        busy  <= 1'b1;
                    end
                end
                SET_PULSE, RESET_PULSE: begin
                    dropped <= set_req | reset_req;
                    if (pcnt >= PCNT_LAST) begin
                        state <= GAP;
                        S     <= OUT_IDLE;
                        R     <= OUT_IDLE;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                GAP: begin
                    dropped <= set_req | reset_req;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    S     <= OUT_IDLE;
                    R     <= OUT_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
